aes_sub_bytes_serial: RTL and testbench



---
 rtl/aes_sub_bytes_serial.sv | 183 ++++++++++++++++++
 tb/tb_aes_sub_bytes_serial.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/aes_sub_bytes_serial.sv
// Iterative SubBytes / InvSubBytes over a 128-bit state using BYTES_PER_CYCLE
// shared Canright composite-field S-boxes (normal basis, GF(((2^2)^2)^2)).
module aes_sub_bytes_serial #(
  parameter int unsigned BYTES_PER_CYCLE = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         op_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o,
  output logic         busy_o
);

  localparam int unsigned NSTEP = 16 / BYTES_PER_CYCLE;
  localparam int unsigned CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NSTEP - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           fsm_q, fsm_d;
  logic [15:0][7:0] state_q, state_d;
  logic             op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       base;
  logic [7:0]       sb_in  [BYTES_PER_CYCLE];
  logic [7:0]       sb_out [BYTES_PER_CYCLE];

  // GF(2^2) multiply, normal basis (W^2, W); ab/cd are the precomputed bit sums.
  function automatic logic [1:0] gf_muls_2(input logic [1:0] a, input logic ab,
                                           input logic [1:0] b, input logic cd);
    logic abcd;
    abcd = ~(ab & cd);
    return {~(a[1] & b[1]) ^ abcd, ~(a[0] & b[0]) ^ abcd};
  endfunction

  function automatic logic [1:0] gf_muls_scl_2(input logic [1:0] a, input logic ab,
                                               input logic [1:0] b, input logic cd);
    logic t;
    t = ~(a[0] & b[0]);
    return {~(ab & cd) ^ t, ~(a[1] & b[1]) ^ t};
  endfunction

  function automatic logic [3:0] gf_inv_4(input logic [3:0] x);
    logic [1:0] a, b, c, d;
    logic       sa, sb, sd;
    a  = x[3:2];
    b  = x[1:0];
    sa = a[1] ^ a[0];
    sb = b[1] ^ b[0];
    c  = {~(a[1] | b[1]) ^ ~(sa & sb), ~(sa | sb) ^ ~(a[0] & b[0])};
    d  = {c[0], c[1]};
    sd = d[1] ^ d[0];
    return {gf_muls_2(d, sd, b, sb), gf_muls_2(d, sd, a, sa)};
  endfunction

  function automatic logic [3:0] gf_muls_4(input logic [3:0] a, input logic [1:0] sa,
                                           input logic al, input logic ah, input logic aa,
                                           input logic [3:0] b, input logic [1:0] sb,
                                           input logic bl, input logic bh, input logic bb);
    logic [1:0] ph, pl, p;
    ph = gf_muls_2(a[3:2], ah, b[3:2], bh);
    pl = gf_muls_2(a[1:0], al, b[1:0], bl);
    p  = gf_muls_scl_2(sa, aa, sb, bb);
    return {ph ^ p, pl ^ p};
  endfunction

  function automatic logic [7:0] gf_inv_8(input logic [7:0] x);
    logic [3:0] a, b, c, d;
    logic [1:0] sa, sb, sd;
    logic       al, ah, aa, bl, bh, bb, dl, dh, dd, c1, c2, c3;
    a  = x[7:4];
    b  = x[3:0];
    sa = a[3:2] ^ a[1:0];
    sb = b[3:2] ^ b[1:0];
    al = a[1] ^ a[0];  ah = a[3] ^ a[2];  aa = sa[1] ^ sa[0];
    bl = b[1] ^ b[0];  bh = b[3] ^ b[2];  bb = sb[1] ^ sb[0];
    c1 = ~(ah & bh);
    c2 = ~(sa[0] & sb[0]);
    c3 = ~(aa & bb);
    c  = {~(sa[0] | sb[0]) ^ ~(a[3] & b[3]) ^ c1 ^ c3,
          ~(sa[1] | sb[1]) ^ ~(a[2] & b[2]) ^ c1 ^ c2,
          ~(al | bl) ^ ~(a[1] & b[1]) ^ c2 ^ c3,
          ~(a[0] | b[0]) ^ ~(al & bl) ^ ~(sa[1] & sb[1]) ^ c2};
    d  = gf_inv_4(c);
    sd = d[3:2] ^ d[1:0];
    dl = d[1] ^ d[0];  dh = d[3] ^ d[2];  dd = sd[1] ^ sd[0];
    return {gf_muls_4(d, sd, dl, dh, dd, b, sb, bl, bh, bb),
            gf_muls_4(d, sd, dl, dh, dd, a, sa, al, ah, aa)};
  endfunction

  // Input/output basis changes have the affine (or inverse affine) step folded in;
  // both candidate results are kept complemented, hence the final inversions.
  function automatic logic [7:0] sbox(input logic [7:0] a, input logic inv);
    logic       r1, r2, r3, r4, r5, r6, r7, r8, r9;
    logic       t1, t2, t3, t4, t5, t6, t7, t8, t9, t10;
    logic [7:0] b, y, z, c, d, x;
    r1 = a[7] ^ a[5];   r2 = a[7] ~^ a[4];  r3 = a[6] ^ a[0];
    r4 = a[5] ~^ r3;    r5 = a[4] ^ r4;     r6 = a[3] ^ a[0];
    r7 = a[2] ^ r1;     r8 = a[1] ^ r3;     r9 = a[3] ^ r8;
    b  = {r7 ~^ r8, r5, a[1] ^ r4, r1 ~^ r3, a[1] ^ r2 ^ r6, ~a[0], r4, a[2] ~^ r9};
    y  = {r2, a[4] ^ r8, a[6] ^ a[4], r9, a[6] ~^ r2, r7, a[4] ^ r6, a[1] ^ r5};
    z  = ~(inv ? y : b);
    c  = gf_inv_8(z);
    t1 = c[7] ^ c[3];   t2 = c[6] ^ c[4];   t3 = c[6] ^ c[0];
    t4 = c[5] ~^ c[3];  t5 = c[5] ~^ t1;    t6 = c[5] ~^ c[1];
    t7 = c[4] ~^ t6;    t8 = c[2] ^ t4;     t9 = c[1] ^ t2;
    t10 = t3 ^ t5;
    d  = {t4, t1, t3, t5, t2 ^ t5, t3 ^ t8, t7, t9};
    x  = {c[4] ~^ c[1], c[1] ^ t10, c[2] ^ t10, c[6] ~^ c[1],
          t8 ^ t9, c[7] ~^ t7, t6, ~c[2]};
    return ~(inv ? x : d);
  endfunction

  assign base = 4'(cnt_q * BYTES_PER_CYCLE);

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
    assign sb_in[g]  = state_q[base + 4'(g)];
    assign sb_out[g] = sbox(sb_in[g], op_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      op_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = data_i;
          op_d    = op_i;
          cnt_d   = '0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
          state_d[base + 4'(j)] = sb_out[j];
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready_i) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (fsm_q == IDLE);
    busy_o      = (fsm_q != IDLE);
    out_valid_o = (fsm_q == DONE);
    data_o      = out_valid_o ? state_q : '0;
  end

endmodule

// File: tb/tb_aes_sub_bytes_serial.sv
// Directed bench for aes_sub_bytes_serial at 1, 4 and 16 bytes per cycle.
module tb_aes_sub_bytes_serial;

  logic         clk = 1'b0;
  logic         rst;
  logic         op_i;
  logic [127:0] data_i;
  logic [2:0]   in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] dout [3];

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];
  logic [127:0] rows    [16];
  logic [127:0] d, e;

  localparam logic [127:0] PT   = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] FWDE = 128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [127:0] INVE = 128'hfbd7f3819ea340bf38a53630d56a0952;

  always #5 clk = ~clk;

  aes_sub_bytes_serial #(.BYTES_PER_CYCLE(1)) u_b1 (
    .clk_i(clk), .rst_i(rst), .op_i(op_i), .in_valid_i(in_valid[0]),
    .in_ready_o(in_ready[0]), .data_i(data_i), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0]), .data_o(dout[0]), .busy_o(busy[0]));

  aes_sub_bytes_serial #(.BYTES_PER_CYCLE(4)) u_b4 (
    .clk_i(clk), .rst_i(rst), .op_i(op_i), .in_valid_i(in_valid[1]),
    .in_ready_o(in_ready[1]), .data_i(data_i), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1]), .data_o(dout[1]), .busy_o(busy[1]));

  aes_sub_bytes_serial #(.BYTES_PER_CYCLE(16)) u_b16 (
    .clk_i(clk), .rst_i(rst), .op_i(op_i), .in_valid_i(in_valid[2]),
    .in_ready_o(in_ready[2]), .data_i(data_i), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready[2]), .data_o(dout[2]), .busy_o(busy[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on DUT g: handshake, latency count, optional
  // op toggling / in_valid pokes, DONE backpressure for 'hold' cycles, release.
  task automatic run(input int g, input logic [127:0] din, input logic op,
                     input logic [127:0] exp, input int exp_lat, input int hold,
                     input bit toggle, input bit poke);
    int lat;
    @(negedge clk);
    data_i = din;
    op_i = op;
    in_valid[g] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    chk("ready_run", 128'(in_ready[g]), 128'd0);
    lat = 0;
    while (out_valid[g] !== 1'b1 && lat < 64) begin
      if (toggle) op_i = ~op_i;
      if (poke) begin
        in_valid[g] = 1'b1;
        data_i = ~din;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid[g] = 1'b0;
    chk("latency", 128'(lat), 128'(exp_lat));
    chk("result", dout[g], exp);
    chk("busy_done", 128'(busy[g]), 128'd1);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid[g] = 1'b1;
        data_i = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk);
      #1;
      chk("hold_valid", 128'(out_valid[g]), 128'd1);
      chk("hold_data", dout[g], exp);
      chk("hold_ready", 128'(in_ready[g]), 128'd0);
    end
    in_valid[g] = 1'b0;
    out_ready[g] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[g] = 1'b0;
    chk("post_valid", 128'(out_valid[g]), 128'd0);
    chk("post_data", dout[g], 128'd0);
    chk("post_ready", 128'(in_ready[g]), 128'd1);
  endtask

  initial begin
    rows[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
    rows[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
    rows[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
    rows[3]  = 128'h04c723c31896059a071280e2eb27b275;
    rows[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
    rows[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
    rows[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
    rows[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
    rows[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
    rows[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
    rows[10] = 128'he0323a0a4906245cc2d3ac629195e479;
    rows[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
    rows[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
    rows[13] = 128'h703eb5664803f60e613557b986c11d9e;
    rows[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
    rows[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;
    for (int r = 0; r < 16; r++)
      for (int j = 0; j < 16; j++)
        sbox_t[16*r+j] = rows[r][127-8*j -: 8];
    for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);

    rst = 1'b1;
    op_i = 1'b0;
    data_i = '0;
    in_valid = '0;
    out_ready = '0;
    #12;
    chk("rst_ready", 128'(in_ready), 128'h7);
    chk("rst_valid", 128'(out_valid), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_data", dout[0], 128'd0);
    @(negedge clk);
    rst = 1'b0;

    run(0, PT, 1'b0, FWDE, 16, 0, 1'b0, 1'b0);
    run(0, FWDE, 1'b1, PT, 16, 0, 1'b0, 1'b0);
    run(0, 128'd0, 1'b1, {16{8'h52}}, 16, 0, 1'b0, 1'b0);
    run(0, 128'd0, 1'b0, {16{8'h63}}, 16, 0, 1'b0, 1'b0);
    run(0, PT, 1'b0, FWDE, 16, 10, 1'b0, 1'b1);
    run(0, PT, 1'b1, INVE, 16, 0, 1'b1, 1'b0);
    run(0, PT, 1'b0, FWDE, 16, 0, 1'b1, 1'b0);

    // Asynchronous reset with cnt_q = 7.
    @(negedge clk);
    data_i = PT;
    op_i = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_busy", 128'(busy[0]), 128'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 128'(out_valid[0]), 128'd0);
    chk("arst_data", dout[0], 128'd0);
    chk("arst_ready", 128'(in_ready[0]), 128'd1);
    chk("arst_busy", 128'(busy[0]), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 128'h53, 1'b0, {{15{8'h63}}, 8'hed}, 16, 0, 1'b0, 1'b0);

    run(1, PT, 1'b0, FWDE, 4, 0, 1'b0, 1'b0);
    run(2, PT, 1'b0, FWDE, 1, 0, 1'b0, 1'b0);
    run(1, PT, 1'b1, INVE, 4, 3, 1'b1, 1'b1);
    run(2, PT, 1'b1, INVE, 1, 3, 1'b1, 1'b1);

    // Every byte value in both directions, sixteen per transaction.
    for (int g = 0; g < 3; g++) begin
      for (int dir = 0; dir < 2; dir++) begin
        for (int t = 0; t < 16; t++) begin
          for (int k = 0; k < 16; k++) begin
            d[8*k +: 8] = 8'(16*t + k);
            e[8*k +: 8] = (dir == 0) ? sbox_t[16*t+k] : isbox_t[16*t+k];
          end
          run(g, d, 1'(dir), e, (g == 0) ? 16 : (g == 1) ? 4 : 1, 0, 1'b0, 1'b0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
